// File: rtl/vga_vram_arbiter.sv
// Arbitrates one single-port video RAM between the VGA prefetch path and a write requester.
// Video fetches win every conflict; 16-pixel words are serialised MSB-first to PixelOut.
module vga_vram_arbiter #(
    parameter int LINE_WORDS = 40,
    parameter int VIS_LINES  = 480,
    parameter int ADDR_W     = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PixelTick,
    input  logic [9:0]        PixelX,
    input  logic [9:0]        PixelY,
    input  logic              VideoOn,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [15:0]       WrData,
    output logic              WrAck,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [15:0]       MemWData,
    input  logic [15:0]       MemRData,
    output logic              PixelOut
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic [9:0]        X_LAST_TRIG = 10'((LINE_WORDS - 1) * 16 + 8);
    localparam logic [9:0]        X_NEXT_LINE = 10'd792;
    localparam logic [9:0]        Y_LAST      = 10'd524;
    localparam logic [9:0]        Y_VIS       = 10'(VIS_LINES);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(LINE_WORDS * VIS_LINES);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [15:0]       prefetch_q, prefetch_d;
    logic [15:0]       cur_word_q, cur_word_d;
    logic              pixel_out_q, pixel_out_d;

    logic [9:0]        next_line;
    logic [9:0]        fetch_line;
    logic [5:0]        fetch_group;
    logic [ADDR_W-1:0] fetch_addr;
    logic              trig_line, trig_next, trigger;
    logic              grant;

    // Trigger decode: next group of this line at X%16==8, group 0 of the next line at X==792.
    always_comb begin
        next_line   = (PixelY == Y_LAST) ? 10'd0 : PixelY + 10'd1;
        trig_line   = PixelTick && (PixelX[3:0] == 4'd8) && (PixelX < X_LAST_TRIG) && (PixelY < Y_VIS);
        trig_next   = PixelTick && (PixelX == X_NEXT_LINE) && (next_line < Y_VIS);
        trigger     = trig_line || trig_next;
        fetch_line  = trig_line ? PixelY : next_line;
        fetch_group = trig_line ? PixelX[9:4] + 6'd1 : 6'd0;
        fetch_addr  = (ADDR_W'(fetch_line) << 5) + (ADDR_W'(fetch_line) << 3) + ADDR_W'(fetch_group);
    end

    // The RAM port is free for writes in every state except FETCH.
    assign grant = WrReq && (state_q != ST_FETCH) && !Reset;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        prefetch_d   = prefetch_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d      = ST_FETCH;
                    fetch_addr_d = fetch_addr;
                end
            end
            ST_FETCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d    = ST_IDLE;
                prefetch_d = MemRData;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // CurWord swaps on the last clock of pixel 15 so pixel 0 of the next group sees the new word.
    always_comb begin
        cur_word_d  = (PixelTick && (PixelX[3:0] == 4'd15)) ? prefetch_q : cur_word_q;
        pixel_out_d = VideoOn & cur_word_q[4'd15 - PixelX[3:0]];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
            prefetch_q   <= '0;
            cur_word_q   <= '0;
            pixel_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            prefetch_q   <= prefetch_d;
            cur_word_q   <= cur_word_d;
            pixel_out_q  <= pixel_out_d;
        end
    end

    // Writes beyond the framebuffer are acknowledged but never reach the RAM.
    assign WrAck    = grant;
    assign MemWe    = grant && (WrAddr < ADDR_LIMIT);
    assign MemAddr  = grant ? WrAddr : fetch_addr_q;
    assign MemWData = Reset ? '0 : WrData;
    assign PixelOut = pixel_out_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: models the sync generator, the RAM and a framebuffer reference.
module tb_vga_vram_arbiter;

    logic        Clk;
    logic        Reset;
    logic        PixelTick;
    logic [9:0]  PixelX;
    logic [9:0]  PixelY;
    logic        VideoOn;
    logic        WrReq;
    logic [14:0] WrAddr;
    logic [15:0] WrData;
    logic        WrAck;
    logic [14:0] MemAddr;
    logic        MemWe;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        PixelOut;

    vga_vram_arbiter #(.LINE_WORDS(40), .VIS_LINES(480), .ADDR_W(15)) dut (
        .Clk(Clk), .Reset(Reset), .PixelTick(PixelTick), .PixelX(PixelX), .PixelY(PixelY),
        .VideoOn(VideoOn), .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrAck(WrAck),
        .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData),
        .PixelOut(PixelOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous single-port RAM, with a preload port used while the DUT is held in reset.
    bit   [15:0] ram    [0:32767];
    bit   [15:0] ref_fb [0:19199];
    logic        pre_we;
    logic [14:0] pre_addr;
    logic [15:0] pre_data;

    always_ff @(posedge Clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (MemWe) ram[MemAddr] <= MemWData;
        MemRData <= ram[MemAddr];
    end

    int   tests, fails;
    int   gx, gy;
    logic gphase;
    int   prev_x, prev_y;
    logic prev_vo;
    logic wr_auto, wr_new, wr_acked, pix_full;
    int   wr_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic exp_pix(input int x, input int y);
        logic [15:0] w;
        w = ref_fb[y * 40 + x / 16];
        return w[15 - (x % 16)];
    endfunction

    task automatic drive();
        PixelX    = 10'(gx);
        PixelY    = 10'(gy);
        PixelTick = gphase;
        VideoOn   = (gx < 640) && (gy < 480);
    endtask

    task automatic set_pos(input int x, input int y);
        gx = x; gy = y; gphase = 1'b0;
        drive();
    endtask

    // Observe the current cycle half a period after its inputs were applied.
    task automatic chk_cycle();
        @(negedge Clk);
        if (!Reset) begin
            if (!prev_vo) check("blank", PixelOut, 0);
            else if (pix_full && prev_y < 4) check("pixel", PixelOut, exp_pix(prev_x, prev_y));
            if (!WrReq) begin
                check("ack_idle", WrAck, 0);
                check("we_idle", MemWe, 0);
            end else if (wr_auto) begin
                wr_acked = WrAck;
                if (WrAck) begin
                    check("wr_addr", MemAddr, WrAddr);
                    check("wr_we", MemWe, (WrAddr < 15'd19200));
                    if (WrAddr < 15'd19200) begin
                        check("wr_data", MemWData, WrData);
                        ref_fb[WrAddr] = WrData;
                    end
                end else begin
                    check("wr_wait", wr_wait, 0);
                end
            end
        end
    endtask

    // Advance one clock: generator steps a pixel every second clock, on the PixelTick edge.
    task automatic adv();
        int r;
        @(posedge Clk);
        #1;
        prev_x  = gx;
        prev_y  = gy;
        prev_vo = VideoOn;
        if (gphase) begin
            gx++;
            if (gx == 800) begin
                gx = 0;
                gy = (gy == 524) ? 0 : gy + 1;
            end
        end
        gphase = !gphase;
        drive();
        if (wr_auto) begin
            if (WrReq) begin
                if (wr_acked) WrReq = 1'b0;
                else wr_wait++;
            end
            wr_acked = 1'b0;
            if (!WrReq && wr_new && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 8) WrAddr = 15'($urandom_range(0, 159));
                else if (r == 8) WrAddr = 15'd19199;
                else WrAddr = 15'(19200 + $urandom_range(0, 50));
                WrData  = 16'($urandom);
                WrReq   = 1'b1;
                wr_wait = 0;
            end
        end
    endtask

    task automatic cyc();
        chk_cycle();
        adv();
    endtask

    initial begin
        tests = 0; fails = 0;
        wr_auto = 1'b0; wr_new = 1'b0; wr_acked = 1'b0; pix_full = 1'b0; wr_wait = 0;
        prev_x = 0; prev_y = 0; prev_vo = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        Reset = 1'b1;
        WrReq = 1'b1; WrAddr = 15'd5; WrData = 16'hFFFF;
        set_pos(0, 0);

        // Reset holds every output low even with a live request.
        for (int i = 0; i < 3; i++) begin
            chk_cycle();
            check("rst_ack", WrAck, 0);
            check("rst_we", MemWe, 0);
            check("rst_addr", MemAddr, 0);
            check("rst_wdata", MemWData, 0);
            check("rst_pix", PixelOut, 0);
            adv();
        end
        WrReq = 1'b0;

        // Preload lines 0..3; line 3 group 2 (address 122) gets the A5A5 pattern.
        for (int i = 0; i < 160; i++) begin
            pre_we   = 1'b1;
            pre_addr = 15'(i);
            pre_data = (i == 122) ? 16'hA5A5 : 16'($urandom);
            ref_fb[i] = pre_data;
            cyc();
        end
        pre_we = 1'b0;
        Reset  = 1'b0;
        cyc(); cyc();

        // Line fetch: Y=3, X=24 fetches address 122, shown over X=32..47.
        set_pos(24, 3);
        cyc(); cyc();
        chk_cycle();
        check("fetch_addr", MemAddr, 122);
        check("fetch_we", MemWe, 0);
        adv();
        for (int i = 0; i < 200 && gx != 49; i++) begin
            chk_cycle();
            if (prev_y == 3 && prev_x >= 32 && prev_x <= 47) check("pix_a5", PixelOut, exp_pix(prev_x, 3));
            adv();
        end

        // No next-line fetch after the last visible line: a write right after is granted at once.
        set_pos(792, 479);
        cyc(); cyc();
        WrReq = 1'b1; WrAddr = 15'd300; WrData = 16'hBEEF;
        chk_cycle();
        check("y479_ack", WrAck, 1);
        check("y479_we", MemWe, 1);
        check("y479_addr", MemAddr, 300);
        adv();
        WrReq = 1'b0; ref_fb[300] = 16'hBEEF;

        // Frame wrap: Y=524, X=792 fetches line 0 group 0; the write waits one cycle.
        set_pos(792, 524);
        cyc(); cyc();
        WrReq = 1'b1; WrAddr = 15'd301; WrData = 16'h0F0F;
        chk_cycle();
        check("wrap_addr", MemAddr, 0);
        check("wrap_ack", WrAck, 0);
        check("wrap_we", MemWe, 0);
        adv();
        chk_cycle();
        check("wrap_late_ack", WrAck, 1);
        check("wrap_late_addr", MemAddr, 301);
        adv();
        WrReq = 1'b0; ref_fb[301] = 16'h0F0F;

        // Collision: trigger at Y=10, X=40 (address 403); write to 100 granted in CAPTURE.
        set_pos(40, 10);
        cyc(); cyc();
        WrReq = 1'b1; WrAddr = 15'd100; WrData = 16'h1234;
        chk_cycle();
        check("coll_fetch_addr", MemAddr, 403);
        check("coll_ack_held", WrAck, 0);
        check("coll_we_held", MemWe, 0);
        adv();
        chk_cycle();
        check("coll_ack", WrAck, 1);
        check("coll_we", MemWe, 1);
        check("coll_addr", MemAddr, 100);
        check("coll_wdata", MemWData, 16'h1234);
        adv();
        WrReq = 1'b0; ref_fb[100] = 16'h1234;

        // Out-of-range write is acknowledged but dropped; the last valid word is written.
        set_pos(700, 100);
        WrReq = 1'b1; WrAddr = 15'd19200; WrData = 16'h5555;
        chk_cycle();
        check("oor_ack", WrAck, 1);
        check("oor_we", MemWe, 0);
        adv();
        WrAddr = 15'd19199;
        chk_cycle();
        check("max_ack", WrAck, 1);
        check("max_we", MemWe, 1);
        adv();
        WrReq = 1'b0; ref_fb[19199] = 16'h5555;

        // Reset during FETCH abandons it; the next trigger fetches normally.
        set_pos(40, 5);
        cyc(); cyc();
        Reset = 1'b1; WrReq = 1'b1; WrAddr = 15'd50; WrData = 16'hFFFF;
        chk_cycle();
        check("mid_rst_ack", WrAck, 0);
        check("mid_rst_we", MemWe, 0);
        check("mid_rst_addr", MemAddr, 0);
        check("mid_rst_wdata", MemWData, 0);
        check("mid_rst_pix", PixelOut, 0);
        adv();
        Reset = 1'b0; WrReq = 1'b0;
        chk_cycle();
        check("post_rst_addr", MemAddr, 0);
        adv();
        WrReq = 1'b1; WrAddr = 15'd50; WrData = 16'h7777;
        chk_cycle();
        check("post_rst_ack", WrAck, 1);
        check("post_rst_we", MemWe, 1);
        adv();
        WrReq = 1'b0; ref_fb[50] = 16'h7777;
        for (int i = 0; i < 100 && !(gx == 56 && gphase); i++) cyc();
        cyc();
        chk_cycle();
        check("post_rst_fetch", MemAddr, 204);
        adv();

        // Random cursor-draw writes across the frame wrap and lines 0..3.
        set_pos(0, 523);
        wr_auto = 1'b1; wr_new = 1'b1; wr_acked = 1'b0;
        for (int i = 0; i < 12000 && gy != 4; i++) cyc();
        wr_new = 1'b0;
        for (int i = 0; i < 4 && WrReq; i++) cyc();
        check("wr_drain_timeout", WrReq, 0);
        WrReq = 1'b0; wr_auto = 1'b0;

        // Read-back: redisplay lines 0..3 with no writes and compare every pixel.
        pix_full = 1'b1;
        set_pos(0, 523);
        for (int i = 0; i < 12000 && gy != 4; i++) cyc();
        pix_full = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
